// File: rtl/mux2_1.sv
// 2-to-1 data selector: combinational result, a registered copy qualified by in_valid,
// a select echo, a one-cycle valid pipe and a saturating count of select transitions.
module mux2_1 #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] one,
   input  logic [WIDTH-1:0] zero,
   input  logic             select,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_valid,
   output logic             sel_q,
   output logic [CNT_W-1:0] sel_changes
);

   logic [WIDTH-1:0] mux_d;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             sel_echo_q;
   logic             prev_sel_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             sel_edge;
   logic             cnt_sat;

   always_comb begin
      mux_d = select ? one : zero;
   end

   assign out = mux_d;

   // prev_sel_q tracks select every cycle, independent of in_valid
   assign sel_edge = (select != prev_sel_q);
   assign cnt_sat  = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (sel_edge && !cnt_sat) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         sel_echo_q <= 1'b0;
         prev_sel_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= in_valid;
         prev_sel_q <= select;
         cnt_q      <= cnt_d;
         if (in_valid) begin
            data_q     <= mux_d;
            sel_echo_q <= select;
         end
      end
   end

   assign out_q       = data_q;
   assign out_valid   = valid_q;
   assign sel_q       = sel_echo_q;
   assign sel_changes = cnt_q;

endmodule

// File: tb/tb_mux2_1.sv
// Bench for mux2_1: directed vectors, registered results checked through a scoreboard queue.
module tb_mux2_1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] one, zero;
   logic       select, in_valid;
   logic [7:0] out, out_q;
   logic       out_valid, sel_q;
   logic [1:0] sel_changes;

   logic       w1_one, w1_zero, w1_sel;
   logic       w1_out, w1_out_q, w1_out_valid, w1_sel_q;
   logic [7:0] w1_sel_changes;

   int errors = 0;
   int checks = 0;

   logic [8:0] sb_q[$];  // {sel, data}

   always #5 clk = ~clk;

   mux2_1 #(.WIDTH(8), .CNT_W(2)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .one         (one),
      .zero        (zero),
      .select      (select),
      .in_valid    (in_valid),
      .out         (out),
      .out_q       (out_q),
      .out_valid   (out_valid),
      .sel_q       (sel_q),
      .sel_changes (sel_changes)
   );

   mux2_1 #(.WIDTH(1)) u_w1 (
      .clk         (clk),
      .rst         (rst),
      .one         (w1_one),
      .zero        (w1_zero),
      .select      (w1_sel),
      .in_valid    (1'b0),
      .out         (w1_out),
      .out_q       (w1_out_q),
      .out_valid   (w1_out_valid),
      .sel_q       (w1_sel_q),
      .sel_changes (w1_sel_changes)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented result must match the oldest queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got out_q=%0h with empty queue, expected none", out_q);
            end else begin
               logic [8:0] e;
               e = sb_q.pop_front();
               chk("sb_out_q", {24'd0, out_q}, {24'd0, e[7:0]});
               chk("sb_sel_q", {31'd0, sel_q}, {31'd0, e[8]});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cnt_exp [5];
      logic [7:0] dat_exp [5];
      cnt_exp = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
      dat_exp = '{8'h20, 8'h31, 8'h22, 8'h33, 8'h24};

      rst = 1'b1; one = '0; zero = '0; select = 1'b0; in_valid = 1'b0;
      w1_one = 1'b0; w1_zero = 1'b0; w1_sel = 1'b0;

      // Combinational path under reset
      #2;
      w1_one = 1'b1; w1_zero = 1'b0; w1_sel = 1'b1;
      #1 chk("w1_sel1", {31'd0, w1_out}, 32'd1);
      #10 w1_sel = 1'b0;
      #1 chk("w1_sel0", {31'd0, w1_out}, 32'd0);

      chk("rst_out_q", {24'd0, out_q}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sel_q", {31'd0, sel_q}, 32'd0);
      chk("rst_sel_changes", {30'd0, sel_changes}, 32'd0);

      one = 8'hA5; zero = 8'h3C; select = 1'b1;
      #1 chk("wide_a", {24'd0, out}, 32'hA5);
      select = 1'b0;
      #1 chk("wide_b", {24'd0, out}, 32'h3C);
      select = 1'b1;
      #1 chk("wide_c", {24'd0, out}, 32'hA5);
      zero = 8'hFF;
      #1 chk("wide_zero_ignored", {24'd0, out}, 32'hA5);
      zero = '0; select = 1'b0;

      tick();
      rst = 1'b0;

      // Select held at 0: no transitions
      repeat (10) tick();
      chk("idle_sel_changes", {30'd0, sel_changes}, 32'd0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Registered path
      one = 8'h11; select = 1'b1; in_valid = 1'b1;
      sb_q.push_back({1'b1, 8'h11});
      tick();
      chk("reg_valid", {31'd0, out_valid}, 32'd1);
      chk("reg_cnt1", {30'd0, sel_changes}, 32'd1);
      in_valid = 1'b0; select = 1'b0;
      tick();
      chk("hold_out_q", {24'd0, out_q}, 32'h11);
      chk("hold_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_sel_q", {31'd0, sel_q}, 32'd1);
      chk("hold_cnt2", {30'd0, sel_changes}, 32'd2);

      // Async reset between edges with a valid result in flight
      zero = 8'h11; in_valid = 1'b1;
      sb_q.push_back({1'b0, 8'h11});
      tick();
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      chk("pre_rst_cnt", {30'd0, sel_changes}, 32'd2);
      #1 rst = 1'b1;
      sb_q.delete();
      #1;
      chk("arst_out_q", {24'd0, out_q}, 32'd0);
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_sel_q", {31'd0, sel_q}, 32'd0);
      chk("arst_sel_changes", {30'd0, sel_changes}, 32'd0);
      zero = 8'h5A;
      #1 chk("arst_out_comb", {24'd0, out}, 32'h5A);
      in_valid = 1'b0;
      tick();
      chk("arst_hold_cnt", {30'd0, sel_changes}, 32'd0);
      rst = 1'b0;

      // Saturation with back-to-back accepts
      for (int i = 0; i < 5; i++) begin
         select = (i % 2 == 0);
         one = 8'h20 + 8'(i);
         zero = 8'h30 + 8'(i);
         in_valid = 1'b1;
         sb_q.push_back({select, dat_exp[i]});
         tick();
         chk($sformatf("sat_cnt%0d", i), {30'd0, sel_changes}, {24'd0, cnt_exp[i]});
      end
      in_valid = 1'b0;
      tick();
      tick();
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
